// File: rtl/attn_value_matmul.sv
// -----------------------------------------------------------------------------
// attn_value_matmul
//
// Attention context stage: context[i][d] = sum_k P[i][k] * V[k][d].
// P (softmax probabilities) is unsigned fixed point, while V and context are
// two's complement. All three use FRAC_BITS fractional bits.
//
// A single multiply-accumulate engine performs one MAC per cycle. Each output
// element takes SEQ_LEN MAC cycles plus one WRITE cycle. done rises on the
// cycle after edge SEQ_LEN*HEAD_DIM*(SEQ_LEN+1)+1, counted from the edge that
// accepts start.
//
// Optional build macro ATTN_ROUND_NEAREST_EN:
//   defined   - round half toward +inf before the scale-down shift
//   undefined - floor truncation (arithmetic shift)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start         run request, sampled only while idle
//   probs_flat    P, element (m,n) at [(m*SEQ_LEN+n)*DATA_WIDTH +: DATA_WIDTH]
//   values_flat   V, element (m,n) at [(m*HEAD_DIM+n)*DATA_WIDTH +: DATA_WIDTH]
//   busy          high from the cycle after accept until done
//   done          single-cycle completion pulse
//   context_flat  result, packed the same way as values_flat
// -----------------------------------------------------------------------------
module attn_value_matmul #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 64,
    parameter int HEAD_DIM   = 64,
    parameter int FRAC_BITS  = 14
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]   probs_flat,
    input  logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0]  values_flat,
    output logic                                    busy,
    output logic                                    done,
    output logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0]  context_flat
);

    localparam int ACC_W = 2*DATA_WIDTH + 1 + $clog2(SEQ_LEN);
    localparam int IW    = (SEQ_LEN  > 1) ? $clog2(SEQ_LEN)  : 1;
    localparam int HW    = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(SEQ_LEN - 1);
    localparam logic [HW-1:0] D_LAST = HW'(HEAD_DIM - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
`ifdef ATTN_ROUND_NEAREST_EN
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'sd1 <<< (FRAC_BITS-1));
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MAC    = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]                                   state;
    logic [IW-1:0]                                i;
    logic [IW-1:0]                                k;
    logic [HW-1:0]                                d;
    logic signed [ACC_W-1:0]                      acc;
    logic [DATA_WIDTH*SEQ_LEN*SEQ_LEN-1:0]        probs_q;
    logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0]       values_q;

    logic [DATA_WIDTH-1:0]                        p_elem;
    logic signed [DATA_WIDTH-1:0]                 v_elem;
    logic signed [2*DATA_WIDTH:0]                 prod;

    // Bring the accumulator back to FRAC_BITS scaling.
    function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef ATTN_ROUND_NEAREST_EN
        return (a + ROUND_HALF) >>> FRAC_BITS;
`else
        return a >>> FRAC_BITS;
`endif
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return a[DATA_WIDTH-1:0];
    endfunction

    // P is unsigned, so give it a zero sign bit before the signed multiply.
    assign p_elem = probs_q[(int'(i)*SEQ_LEN + int'(k))*DATA_WIDTH +: DATA_WIDTH];
    assign v_elem = values_q[(int'(k)*HEAD_DIM + int'(d))*DATA_WIDTH +: DATA_WIDTH];
    assign prod   = $signed({1'b0, p_elem}) * v_elem;

    // Operand snapshot. This is data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            probs_q  <= probs_flat;
            values_q <= values_flat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            i            <= '0;
            k            <= '0;
            d            <= '0;
            acc          <= '0;
            context_flat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        i     <= '0;
                        k     <= '0;
                        d     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == I_LAST) begin
                        k     <= '0;
                        state <= S_WRITE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_WRITE: begin
                    context_flat[(int'(i)*HEAD_DIM + int'(d))*DATA_WIDTH +: DATA_WIDTH] <= sat(scale(acc));
                    acc <= '0;
                    if (d == D_LAST) begin
                        d <= '0;
                        i <= (i == I_LAST) ? '0 : i + 1'b1;
                    end else begin
                        d <= d + 1'b1;
                    end
                    state <= (i == I_LAST && d == D_LAST) ? S_FINISH : S_MAC;
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_value_matmul.sv
// -----------------------------------------------------------------------------
// tb_attn_value_matmul
//
// Directed bench for attn_value_matmul with SEQ_LEN=4, HEAD_DIM=2,
// DATA_WIDTH=16 and FRAC_BITS=14. Each run must finish 41 edges after accept.
// The floor/round vector follows ATTN_ROUND_NEAREST_EN.
// -----------------------------------------------------------------------------
module tb_attn_value_matmul;

    localparam int DW  = 16;
    localparam int SL  = 4;
    localparam int HD  = 2;
    localparam int FB  = 14;
    localparam int LAT = SL*HD*(SL+1) + 1;
    localparam int CTX_W = DW*SL*HD;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [DW*SL*SL-1:0]   probs_flat = '0;
    logic [CTX_W-1:0]      values_flat = '0;
    logic                  busy;
    logic                  done;
    logic [CTX_W-1:0]      context_flat;

    int vectors = 0;
    int miscompares = 0;

    attn_value_matmul #(
        .DATA_WIDTH(DW),
        .SEQ_LEN(SL),
        .HEAD_DIM(HD),
        .FRAC_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .probs_flat(probs_flat),
        .values_flat(values_flat),
        .busy(busy),
        .done(done),
        .context_flat(context_flat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CTX_W-1:0] obs, input logic [CTX_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input int m, input int n, input logic [DW-1:0] v);
        probs_flat[(m*SL+n)*DW +: DW] = v;
    endtask

    task automatic set_v(input int m, input int n, input logic [DW-1:0] v);
        values_flat[(m*HD+n)*DW +: DW] = v;
    endtask

    task automatic fill_p(input logic [DW-1:0] v);
        for (int m = 0; m < SL; m++)
            for (int n = 0; n < SL; n++)
                set_p(m, n, v);
    endtask

    task automatic fill_v(input logic [DW-1:0] v);
        for (int m = 0; m < SL; m++)
            for (int n = 0; n < HD; n++)
                set_v(m, n, v);
    endtask

    // Start one run and wait for done.
    // With disturb set, P is corrupted right after accept and start is
    // pulsed again at cycle 10. Neither may change the run.
    task automatic run_check(input string tag, input logic [CTX_W-1:0] exp_ctx, input bit disturb);
        int edges;
        int extra_dones;
        bit busy_ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (disturb) probs_flat = '1;
        edges = 0;
        busy_ok = 1'b1;
        while (!done && edges < 200) begin
            if (!busy) busy_ok = 1'b0;
            start = disturb && (edges == 10);
            tick();
            edges++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, CTX_W'(edges), CTX_W'(LAT));
        chk({tag, "_busy_during"}, CTX_W'(busy_ok), CTX_W'(1));
        chk({tag, "_busy_at_done"}, CTX_W'(busy), CTX_W'(0));
        chk({tag, "_context"}, context_flat, exp_ctx);
        extra_dones = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done) extra_dones++;
        end
        chk({tag, "_single_done"}, CTX_W'(extra_dones), CTX_W'(0));
    endtask

    initial begin
        logic [CTX_W-1:0] exp;
        int late_done;

        // Reset state.
        #2 rst = 1'b0;
        tick();
        tick();
        chk("reset_busy", CTX_W'(busy), CTX_W'(0));
        chk("reset_done", CTX_W'(done), CTX_W'(0));
        chk("reset_context", context_flat, '0);
        rst = 1'b1;
        tick();

        // Identity P with distinct V values, including negatives.
        fill_p(16'h0000);
        for (int m = 0; m < SL; m++) set_p(m, m, 16'h4000);
        set_v(0, 0, 16'h1234); set_v(0, 1, 16'hFEDC);
        set_v(1, 0, 16'h0800); set_v(1, 1, 16'h3FFF);
        set_v(2, 0, 16'h0001); set_v(2, 1, 16'hC000);
        set_v(3, 0, 16'h8000); set_v(3, 1, 16'h7FFF);
        exp = values_flat;
        run_check("identity", exp, 1'b0);

        // Uniform P = 0.25 with constant V columns.
        fill_p(16'h1000);
        for (int m = 0; m < SL; m++) begin
            set_v(m, 0, 16'h2000);
            set_v(m, 1, 16'hE000);
        end
        exp = {SL{16'hE000, 16'h2000}};
        run_check("uniform", exp, 1'b0);

        // Saturation in both directions.
        fill_p(16'h4000);
        fill_v(16'h7FFF);
        run_check("sat_pos", {SL*HD{16'h7FFF}}, 1'b0);
        fill_v(16'h8000);
        run_check("sat_neg", {SL*HD{16'h8000}}, 1'b0);

        // Reset at cycle 20 of a run.
        fill_p(16'h1000);
        for (int m = 0; m < SL; m++) begin
            set_v(m, 0, 16'h2000);
            set_v(m, 1, 16'hE000);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b0;
        #1;
        chk("midreset_busy", CTX_W'(busy), CTX_W'(0));
        chk("midreset_done", CTX_W'(done), CTX_W'(0));
        chk("midreset_context", context_flat, '0);
        tick();
        rst = 1'b1;
        late_done = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done || busy) late_done++;
        end
        chk("midreset_aborted", CTX_W'(late_done), CTX_W'(0));
        run_check("after_reset", {SL{16'hE000, 16'h2000}}, 1'b0);

        // Ignore a second start and any P change after accept.
        fill_p(16'h0000);
        for (int m = 0; m < SL; m++) set_p(m, m, 16'h4000);
        set_v(0, 0, 16'h0123); set_v(0, 1, 16'hF00D);
        set_v(1, 0, 16'h5A5A); set_v(1, 1, 16'h8001);
        set_v(2, 0, 16'h7FFE); set_v(2, 1, 16'hC000);
        set_v(3, 0, 16'h0040); set_v(3, 1, 16'hFFFF);
        exp = values_flat;
        run_check("handshake", exp, 1'b1);

        // Floor versus round-half-up on a tiny negative product.
        fill_p(16'h0000);
        fill_v(16'h0000);
        set_p(0, 0, 16'h0001);
        set_v(0, 0, 16'hFFFF);
`ifdef ATTN_ROUND_NEAREST_EN
        exp = '0;
`else
        exp = CTX_W'(16'hFFFF);
`endif
        run_check("floor_round", exp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/attn_value_matmul.md
Name: attn_value_matmul

Overview:
- Consumes the row-normalised probability matrix produced by the softmax stage and multiplies it by the value matrix: context[i][d] = sum_k P[i][k]*V[k][d].
- Sits directly downstream of softmax in the self-attention datapath, using the same start/done, flattened-bus handshake.
- Sequential single-MAC engine: one multiply-accumulate per cycle, fixed latency.

Parameters:
- DATA_WIDTH, 16, width of every matrix element
- SEQ_LEN, 64, rows/cols of P; rows of V
- HEAD_DIM, 64, columns of V and of context
- FRAC_BITS, 14, fractional bits of P, V and context (1.0 = 1<<FRAC_BITS)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- probs_flat  input  DATA_WIDTH*SEQ_LEN*SEQ_LEN  P, element (m,n) at bits [(m*SEQ_LEN+n)*DATA_WIDTH +: DATA_WIDTH], unsigned
- values_flat  input  DATA_WIDTH*SEQ_LEN*HEAD_DIM  V, element (m,n) at [(m*HEAD_DIM+n)*DATA_WIDTH +: DATA_WIDTH], two's complement
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle completion pulse
- context_flat  output  DATA_WIDTH*SEQ_LEN*HEAD_DIM  result, same packing as values_flat, two's complement

Behaviour:
- Reset (rst low, asynchronous): state IDLE, busy=0, done=0, all context elements 0, counters and accumulator 0. Reset mid-run aborts; no done is produced.
- States: IDLE, MAC, WRITE, FINISH.
- IDLE: done=0. If start=1, snapshot probs_flat and values_flat into internal registers, clear i, d, k and acc, set busy=1, go to MAC. Inputs may change after the accept edge.
- MAC: acc += zext(P[i][k]) * sext(V[k][d]).
  - k increments each cycle.
  - When k == SEQ_LEN-1, clear k and go to WRITE.
- WRITE: context[i][d] <= sat(acc >>> FRAC_BITS); clear acc.
  - d increments; on d == HEAD_DIM-1, d wraps to 0 and i increments.
  - If i == SEQ_LEN-1 and d == HEAD_DIM-1, go to FINISH; otherwise go to MAC.
- FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: done is high on the cycle following clock edge N after the accept edge, where N = SEQ_LEN*HEAD_DIM*(SEQ_LEN+1)+1.
- start while busy is ignored. start held high after FINISH triggers a new run; back-to-back runs have one IDLE cycle between them.
- Arithmetic:
  - Product is DATA_WIDTH+1 by DATA_WIDTH signed.
  - Accumulator width ACC_W = 2*DATA_WIDTH+1+$clog2(SEQ_LEN); no intermediate overflow.
  - Shift is arithmetic (floor toward -inf).
  - Saturate to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1].
- context_flat elements update as they are written and hold their value between runs. Elements not yet rewritten keep the previous run's values until done.

Optional Feature:
- Macro: ATTN_ROUND_NEAREST_EN.
- Defined: in WRITE, add 1<<(FRAC_BITS-1) to acc before the shift (round half toward +inf), then saturate.
- Undefined: plain floor truncation as above. Latency is identical in both builds.

Test Plan:
All scenarios use DATA_WIDTH=16, SEQ_LEN=4, HEAD_DIM=2, FRAC_BITS=14, so N = 41.
- Identity P (0x4000 on the diagonal, 0 elsewhere), V = distinct values incl. negatives (e.g. V[2][1]=0xC000) -> context == V exactly; done pulses once, 41 edges after accept; busy high throughout.
- Uniform P = 0x1000 (0.25) everywhere, V column 0 all 0x2000, column 1 all 0xE000 -> every context[i][0]=0x2000, context[i][1]=0xE000.
- Saturation: P all 0x4000.
  - V all 0x7FFF -> context all 0x7FFF.
  - V all 0x8000 -> context all 0x8000.
- Floor vs round: P[0][0]=0x0001, V[0][0]=0xFFFF, all else 0.
  - Default build: context[0][0]=0xFFFF.
  - ATTN_ROUND_NEAREST_EN build: context[0][0]=0x0000.
  - All other elements 0 in both builds.
- Handshake:
  - Pulse start again at cycle 10 of a run -> ignored; single done at 41.
  - Change probs_flat after accept -> result reflects the snapshot.
- Reset: assert rst low at cycle 20 of a run -> busy, done and context go to 0 immediately. After release, a new start completes normally in 41.
